// File: rtl/grid_game_engine.sv
`default_nettype none
// ============================================================================
// Module   : grid_game_engine
// Purpose  : Tick-driven fire/gold grid game controller with lives, score,
//            per-tick damage de-duplication, post-hit shield and timed gold.
// Revision : 1.0 - initial release
// ============================================================================
module grid_game_engine #(
    parameter int               CELLS        = 9,
    parameter int               LIFE_MAX     = 5,
    parameter int               SCORE_MAX    = 3,
    parameter logic [CELLS-1:0] FIRE_SEED    = 9'b100110110,
    parameter logic [CELLS-1:0] FIRE_TAPS    = 9'b001101000,
    parameter logic [CELLS-1:0] GOLD_SEED    = 9'b100010000,
    parameter int               GOLD_PERIOD  = 3,
    parameter int               GOLD_HOLD    = 2,
    parameter int               SHIELD_TICKS = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             tick,
    input  logic                             start,
    input  logic                             super_mode,
    input  logic [CELLS-1:0]                 box,
    output logic [1:0]                       game_state,
    output logic [$clog2(SCORE_MAX+1)-1:0]   score,
    output logic [$clog2(LIFE_MAX+1)-1:0]    life,
    output logic [CELLS-1:0]                 fire_state,
    output logic [CELLS-1:0]                 gold_state,
    output logic [CELLS-1:0]                 hit_bitmap,
    output logic                             shield_active,
    output logic                             win
);

    localparam int c_life_w  = $clog2(LIFE_MAX + 1);
    localparam int c_score_w = $clog2(SCORE_MAX + 1);
    localparam int c_pc_w    = $clog2(CELLS + 1);
    localparam int c_dw      = (c_pc_w > c_life_w) ? c_pc_w : c_life_w;
    localparam int c_sh_w    = (SHIELD_TICKS > 0) ? $clog2(SHIELD_TICKS + 1) : 1;
    localparam int c_per_w   = $clog2(GOLD_PERIOD + 1);
    localparam int c_hold_w  = $clog2(GOLD_HOLD + 1);

    localparam logic [CELLS-1:0]    c_taps      = FIRE_TAPS & {1'b0, {(CELLS-1){1'b1}}};
    localparam logic [c_life_w-1:0] c_life_init = c_life_w'(LIFE_MAX);
    localparam logic [c_score_w-1:0] c_score_max = c_score_w'(SCORE_MAX);
    localparam logic [c_sh_w-1:0]   c_sh_init   = c_sh_w'(SHIELD_TICKS);
    localparam logic [c_per_w-1:0]  c_per_last  = c_per_w'(GOLD_PERIOD - 1);
    localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(GOLD_HOLD - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PLAY   = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t               r_state, w_state_n;
    logic                 r_start_q;
    logic [CELLS-1:0]     r_fire_q, r_gold, r_hit, r_gold_lfsr;
    logic [c_life_w-1:0]  r_life;
    logic [c_score_w-1:0] r_score;
    logic [c_sh_w-1:0]    r_shield;
    logic                 r_win;
    logic [c_per_w-1:0]   r_gold_cnt;
    logic [c_hold_w-1:0]  r_hold_cnt;

    logic [CELLS-1:0]     w_fire_n, w_gold_n, w_hit_n, w_gold_lfsr_n;
    logic [c_life_w-1:0]  w_life_n;
    logic [c_score_w-1:0] w_score_n;
    logic [c_sh_w-1:0]    w_shield_n;
    logic                 w_win_n;
    logic [c_per_w-1:0]   w_gold_cnt_n;
    logic [c_hold_w-1:0]  w_hold_cnt_n;

    logic                 w_start_rise, w_end, w_damage, w_catch;
    logic [CELLS-1:0]     w_fire_adv, w_gold_adv, w_hit_base, w_new_hits;
    logic [CELLS-1:0]     w_cand, w_pick;
    logic [c_pc_w-1:0]    w_pc;
    logic [c_dw-1:0]      w_life_ext, w_pc_ext;
    logic [c_life_w-1:0]  w_life_dec;

    // Galois step; an all-zero result is replaced by the seed so the LFSR never locks up.
    function automatic logic [CELLS-1:0] lfsr_step(input logic [CELLS-1:0] f,
                                                   input logic [CELLS-1:0] seed);
        logic [CELLS-1:0] r;
        r = {f[0], f[CELLS-1:1]} ^ ({CELLS{f[0]}} & c_taps);
        if (r == '0) begin
            r = seed;
        end
        return r;
    endfunction

    always_comb begin
        w_start_rise = start & ~r_start_q;
        w_fire_adv   = lfsr_step(r_fire_q, FIRE_SEED);
        w_gold_adv   = lfsr_step(r_gold_lfsr, GOLD_SEED);
        // A tick opens a new damage period, so the old bitmap no longer masks hits.
        w_hit_base   = tick ? '0 : r_hit;
        w_new_hits   = box & r_fire_q & ~w_hit_base & ~r_gold;
        w_pc         = '0;
        for (int i = 0; i < CELLS; i++) begin
            w_pc = w_pc + c_pc_w'(w_new_hits[i]);
        end
        w_damage     = (|w_new_hits) & ~super_mode & (r_shield == '0);
        w_catch      = |(box & r_gold);
        w_cand       = w_gold_adv & ~w_fire_adv;
        w_pick       = w_cand & (~w_cand + CELLS'(1));
        w_life_ext   = c_dw'(r_life);
        w_pc_ext     = c_dw'(w_pc);
        w_life_dec   = (w_pc_ext >= w_life_ext) ? '0 : c_life_w'(w_life_ext - w_pc_ext);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_end     = (r_life == '0) || (r_score == c_score_max);
        case (r_state)
            S_IDLE:   if (w_start_rise) w_state_n = S_PLAY;
            S_PLAY:   if (w_end)        w_state_n = S_FINISH;
            S_FINISH: if (w_start_rise) w_state_n = S_IDLE;
            default:  w_state_n = S_IDLE;
        endcase
    end

    always_comb begin
        w_fire_n      = r_fire_q;
        w_gold_n      = r_gold;
        w_hit_n       = r_hit;
        w_gold_lfsr_n = r_gold_lfsr;
        w_life_n      = r_life;
        w_score_n     = r_score;
        w_shield_n    = r_shield;
        w_win_n       = r_win;
        w_gold_cnt_n  = r_gold_cnt;
        w_hold_cnt_n  = r_hold_cnt;
        case (r_state)
            S_IDLE: begin
                w_fire_n      = FIRE_SEED;
                w_gold_n      = '0;
                w_hit_n       = '0;
                w_gold_lfsr_n = GOLD_SEED;
                w_life_n      = c_life_init;
                w_score_n     = '0;
                w_shield_n    = '0;
                w_win_n       = 1'b0;
                w_gold_cnt_n  = '0;
                w_hold_cnt_n  = '0;
            end
            S_PLAY: begin
                if (tick) begin
                    w_fire_n = w_fire_adv;
                end
                w_hit_n = w_hit_base;
                if (w_damage) begin
                    w_hit_n    = w_hit_base | w_new_hits;
                    w_life_n   = w_life_dec;
                    w_shield_n = c_sh_init;
                end else if (tick && (r_shield != '0)) begin
                    w_shield_n = r_shield - 1'b1;
                end
                // A catch takes precedence over expiry in the same cycle.
                if (r_gold != '0) begin
                    if (w_catch) begin
                        w_gold_n     = '0;
                        w_gold_cnt_n = '0;
                        w_hold_cnt_n = '0;
                        if (r_score != c_score_max) begin
                            w_score_n = r_score + 1'b1;
                        end
                    end else if (tick) begin
                        if (r_hold_cnt == c_hold_last) begin
                            w_gold_n     = '0;
                            w_hold_cnt_n = '0;
                        end else begin
                            w_hold_cnt_n = r_hold_cnt + 1'b1;
                        end
                    end
                end else if (tick) begin
                    if (r_gold_cnt == c_per_last) begin
                        w_gold_lfsr_n = w_gold_adv;
                        w_gold_n      = w_pick;
                        w_gold_cnt_n  = '0;
                        w_hold_cnt_n  = '0;
                    end else begin
                        w_gold_cnt_n = r_gold_cnt + 1'b1;
                    end
                end
                if (w_end) begin
                    w_win_n = (r_score == c_score_max);
                end
            end
            S_FINISH: begin
                w_gold_n = '0;
            end
            default: begin
                w_gold_n = '0;
            end
        endcase
    end

    // start_q is not reloaded in IDLE so a held start cannot look like a new edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_start_q   <= 1'b0;
            r_fire_q    <= FIRE_SEED;
            r_gold      <= '0;
            r_hit       <= '0;
            r_gold_lfsr <= GOLD_SEED;
            r_life      <= c_life_init;
            r_score     <= '0;
            r_shield    <= '0;
            r_win       <= 1'b0;
            r_gold_cnt  <= '0;
            r_hold_cnt  <= '0;
        end else begin
            r_start_q   <= start;
            r_fire_q    <= w_fire_n;
            r_gold      <= w_gold_n;
            r_hit       <= w_hit_n;
            r_gold_lfsr <= w_gold_lfsr_n;
            r_life      <= w_life_n;
            r_score     <= w_score_n;
            r_shield    <= w_shield_n;
            r_win       <= w_win_n;
            r_gold_cnt  <= w_gold_cnt_n;
            r_hold_cnt  <= w_hold_cnt_n;
        end
    end

    assign game_state    = r_state;
    assign score         = r_score;
    assign life          = r_life;
    assign fire_state    = r_fire_q & ~r_hit;
    assign gold_state    = r_gold;
    assign hit_bitmap    = r_hit;
    assign shield_active = (r_shield != '0);
    assign win           = r_win;

endmodule
`default_nettype wire

// File: doc/grid_game_engine.md
Name: grid_game_engine

Overview:
Parametrised successor of the 3x3 fire/gold game controller. Supports any grid size, configurable life and score limits, and LFSR taps/seeds. Runs on a single clock `clk` with a game-rate `tick` strobe instead of a divided clock. Adds per-tick de-duplicated damage, post-hit shield, timed gold lifetime and edge-detected start. Sits between the keypad/box decoder and the LED/7-segment display blocks.

Parameters:
CELLS, 9, number of grid cells (≥2)
LIFE_MAX, 5, starting lives
SCORE_MAX, 3, golds needed to win
FIRE_SEED, 9'b100110110, fire LFSR reset/IDLE value (CELLS bits, nonzero)
FIRE_TAPS, 9'b001101000, Galois feedback mask (MSB excluded)
GOLD_SEED, 9'b100010000, gold-position LFSR seed (nonzero)
GOLD_PERIOD, 3, empty ticks before a spawn attempt (≥1)
GOLD_HOLD, 2, ticks a gold stays before expiring (≥1)
SHIELD_TICKS, 2, invulnerable ticks after damage (0 disables)

Ports:
clk  in  1  system clock
rst  in  1  reset (see Behaviour)
tick  in  1  one-cycle game-rate strobe
start  in  1  start/restart level; edge-detected internally
super  in  1  cheat: blocks all damage while high
box  in  CELLS  player-occupied cells
game_state  out  2  0=IDLE 1=PLAY 2=FINISH
score  out  clog2(SCORE_MAX+1)  golds caught
life  out  clog2(LIFE_MAX+1)  remaining lives
fire_state  out  CELLS  visible fire = fire_q & ~hit_bitmap
gold_state  out  CELLS  current gold, one-hot or zero
hit_bitmap  out  CELLS  cells that caused damage this tick period
shield_active  out  1  shield counter nonzero
win  out  1  set in FINISH when score reached SCORE_MAX

Behaviour:
- Reset rst, asynchronous, active-high; clock clk.
- Reset values:
  - game_state=0, score=0, life=LIFE_MAX
  - fire_q=FIRE_SEED, gold=0, hit_bitmap=0
  - shield=0, win=0, gold LFSR=GOLD_SEED
  - start_q=0, gold counters=0
- `start_rise = start & ~start_q`; `start_q` is registered every cycle.
- FSM:
  - IDLE→PLAY on start_rise.
  - PLAY→FINISH the cycle after life==0 or score==SCORE_MAX is registered.
  - FINISH→IDLE on start_rise.
  - A held start does not retrigger.
- IDLE: continuously reloads all reset values except game_state. tick is ignored in IDLE and FINISH.
- FINISH: fire_q, life, score frozen; gold cleared; hit_bitmap held.
- Fire LFSR (PLAY, on tick):
  - `fire_q <= {f[0], f[CELLS-1:1]} ^ ({CELLS{f[0]}} & FIRE_TAPS)`.
  - If the result is all-zero, load FIRE_SEED instead.
  - hit_bitmap clears on the same tick.
- Damage (PLAY, every cycle):
  - `new_hits = box & fire_q & ~hit_bitmap & ~gold_state`.
  - If new_hits≠0 and !super and !shield_active: `life <= sat0(life - popcount(new_hits))`, `hit_bitmap |= new_hits`, `shield <= SHIELD_TICKS`.
  - Otherwise life and hit_bitmap are unchanged; blocked hits are not recorded.
  - A cell damages at most once per tick period.
  - Tick and new hit in the same cycle: hit is evaluated against the pre-tick fire_q and the bitmap is cleared first; the new hit bits are then set.
- Shield: decrements on tick while nonzero.
- Gold (PLAY):
  - While gold==0, count ticks. On the tick where count==GOLD_PERIOD-1:
    - advance gold LFSR (same Galois form, FIRE_TAPS);
    - place gold at the lowest i with `rnd[i] & ~fire_next[i]`;
    - reset count.
    - No eligible cell → no spawn, count restarts.
  - A spawned gold expires after GOLD_HOLD ticks.
  - Catch: `box & gold_state ≠ 0` in any cycle → `score <= min(score+1, SCORE_MAX)`, gold cleared next cycle, empty counter zeroed. Catch beats a same-cycle expiry.
- Gold cell overlapping fire never damages.
- Win/loss:
  - `win <= (score==SCORE_MAX)` on entry to FINISH.
  - If life reaches 0 and score reaches SCORE_MAX in the same cycle, win=1.
- rst mid-game returns everything to reset values immediately.

Test Plan:
- Reset, start pulse → game_state 0→1 one cycle after edge. Ticks give fire 100110110 → 010011011 → 100100101. Holding start high through FINISH does not restart.
- PLAY, fire=010011011, box=000000001 → life 5→4, hit_bitmap=000000001, fire_state=010011010, shield_active=1 for exactly 2 ticks. A second box toggle within the shield leaves life=4.
- SHIELD_TICKS=0, box=000011011 on fire 010011011 → life 5→1 in one cycle. Next tick plus hit → life 0, FINISH next cycle, win=0.
- super=1 with box fully overlapping fire for 10 ticks → life stays 5, hit_bitmap stays 0.
- Gold spawns after 3 empty ticks on a non-fire cell. Box on it → score+1, gold_state=0 next cycle. Three catches → FINISH, win=1. A gold left untouched disappears after 2 ticks.
- CELLS=16 build (nonzero seeds, custom taps): run 1000 ticks → fire_q never all-zero, gold always one-hot/zero, life/score never wrap.
